ddr_burst_writer: RTL and testbench

Sequences AXI4 write bursts on the axi0 LPDDR4 port so captured 512-bit sample words can be archived to DDR. It accepts one write descriptor (start address, beat count) at a time and splits it into legal INCR bursts. It streams data beats from an upstream valid/ready source onto W, collects each B response, and reports completion and error status. It sits between the capture/readout logic and the axi0 master pins on the axi0_ACLK domain.

---
 rtl/ddr_wr_pkg.sv | 23 ++
 rtl/ddr_burst_len_calc.sv | 42 ++++
 rtl/ddr_burst_writer.sv | 185 ++++++++++++++++++
 tb/tb_ddr_burst_writer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_wr_pkg.sv
// rtl/ddr_wr_pkg.sv - shared types and AXI constants for the DDR burst writer
package ddr_wr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2,
    ST_B    = 2'd3
  } wr_state_e;

  localparam int          BEAT_BYTES     = 64;
  localparam int          BEAT_SHIFT     = 6;
  localparam int          BEATS_PER_4K   = 64;
  localparam logic [2:0]  AXI_SIZE_64B   = 3'b110;
  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ddr_burst_len_calc.sv
// rtl/ddr_burst_len_calc.sv - next burst length; 4 KB split enabled by DDR_WR_4K_SPLIT_EN
module ddr_burst_len_calc
  import ddr_wr_pkg::*;
#(
  parameter int MAX_BURST = 64
) (
  input  logic [15:0] remaining_i,
  input  logic [5:0]  beat_idx_i,
  output logic [8:0]  len_o
);

  localparam logic [15:0] MAX_B = 16'(MAX_BURST);

  logic [15:0] cap;
  logic        unused_cap_hi;

`ifdef DDR_WR_4K_SPLIT_EN
  logic [15:0] bnd;

  // Smallest of remaining beats, burst cap and beats left before the next 4 KB line.
  always_comb begin
    bnd = 16'(BEATS_PER_4K) - {10'd0, beat_idx_i};
    cap = (remaining_i < MAX_B) ? remaining_i : MAX_B;
    if (bnd < cap) begin
      cap = bnd;
    end
  end
`else
  logic unused_idx;

  assign unused_idx = ^beat_idx_i;

  // Caller keeps descriptors inside one 4 KB region, so only the burst cap applies.
  always_comb begin
    cap = (remaining_i < MAX_B) ? remaining_i : MAX_B;
  end
`endif

  assign len_o         = cap[8:0];
  assign unused_cap_hi = ^cap[15:9];

endmodule

// File: rtl/ddr_burst_writer.sv
// rtl/ddr_burst_writer.sv - splits a write descriptor into AXI4 INCR bursts (DDR_WR_4K_SPLIT_EN selects 4 KB splitting)
module ddr_burst_writer
  import ddr_wr_pkg::*;
#(
  parameter int          ADDR_W    = 33,
  parameter int          DATA_W    = 512,
  parameter int          MAX_BURST = 64,
  parameter logic [5:0]  AXI_ID    = 6'd0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [ADDR_W-1:0]     cmd_addr_i,
  input  logic [15:0]           cmd_beats_i,
  input  logic                  s_tvalid_i,
  output logic                  s_tready_o,
  input  logic [DATA_W-1:0]     s_tdata_i,
  output logic                  axi0_AWVALID_o,
  input  logic                  axi0_AWREADY_i,
  output logic [ADDR_W-1:0]     axi0_AWADDR_o,
  output logic [7:0]            axi0_AWLEN_o,
  output logic [2:0]            axi0_AWSIZE_o,
  output logic [1:0]            axi0_AWBURST_o,
  output logic [5:0]            axi0_AWID_o,
  output logic [3:0]            axi0_AWCACHE_o,
  output logic                  axi0_AWLOCK_o,
  output logic                  axi0_AWQOS_o,
  output logic                  axi0_AWAPCMD_o,
  output logic                  axi0_AWCOBUF_o,
  output logic                  axi0_AWALLSTRB_o,
  output logic                  axi0_WVALID_o,
  input  logic                  axi0_WREADY_i,
  output logic [DATA_W-1:0]     axi0_WDATA_o,
  output logic [DATA_W/8-1:0]   axi0_WSTRB_o,
  output logic                  axi0_WLAST_o,
  input  logic                  axi0_BVALID_i,
  output logic                  axi0_BREADY_o,
  input  logic [1:0]            axi0_BRESP_i,
  input  logic [5:0]            axi0_BID_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [15:0]           err_count_o,
  output logic [31:0]           beats_written_o
);

  wr_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       remaining_q, remaining_d;
  logic [8:0]        len_q, len_d;
  logic [8:0]        beat_cnt_q, beat_cnt_d;
  logic              done_q, done_d;
  logic [15:0]       err_count_q, err_count_d;
  logic [31:0]       beats_written_q, beats_written_d;

  logic [8:0]        burst_len;
  logic [8:0]        len_m1;
  logic              is_aw, is_w, is_b;
  logic              unused_ok;

  ddr_burst_len_calc #(
    .MAX_BURST (MAX_BURST)
  ) u_len_calc (
    .remaining_i (remaining_q),
    .beat_idx_i  (addr_q[11:6]),
    .len_o       (burst_len)
  );

  assign is_aw  = (state_q == ST_AW);
  assign is_w   = (state_q == ST_W);
  assign is_b   = (state_q == ST_B);
  assign len_m1 = burst_len - 9'd1;

  // Next-state and datapath updates; one burst outstanding at a time.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    remaining_d     = remaining_q;
    len_d           = len_q;
    beat_cnt_d      = beat_cnt_q;
    done_d          = 1'b0;
    err_count_d     = err_count_q;
    beats_written_d = beats_written_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i && cmd_ready_o) begin
          addr_d      = {cmd_addr_i[ADDR_W-1:BEAT_SHIFT], {BEAT_SHIFT{1'b0}}};
          remaining_d = cmd_beats_i;
          if (cmd_beats_i == 16'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_AW;
          end
        end
      end
      ST_AW: begin
        if (axi0_AWREADY_i) begin
          len_d      = burst_len;
          beat_cnt_d = burst_len;
          state_d    = ST_W;
        end
      end
      ST_W: begin
        if (s_tvalid_i && axi0_WREADY_i) begin
          beat_cnt_d      = beat_cnt_q - 9'd1;
          beats_written_d = beats_written_q + 32'd1;
          if (beat_cnt_q == 9'd1) begin
            state_d = ST_B;
          end
        end
      end
      ST_B: begin
        if (axi0_BVALID_i) begin
          if (axi0_BRESP_i != AXI_RESP_OKAY) begin
            err_count_d = sat_inc16(err_count_q);
          end
          addr_d      = addr_q + ADDR_W'({len_q, {BEAT_SHIFT{1'b0}}});
          remaining_d = remaining_q - 16'(len_q);
          if (remaining_q == 16'(len_q)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_AW;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any burst in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      remaining_q     <= '0;
      len_q           <= '0;
      beat_cnt_q      <= '0;
      done_q          <= 1'b0;
      err_count_q     <= '0;
      beats_written_q <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remaining_q     <= remaining_d;
      len_q           <= len_d;
      beat_cnt_q      <= beat_cnt_d;
      done_q          <= done_d;
      err_count_q     <= err_count_d;
      beats_written_q <= beats_written_d;
    end
  end

  assign cmd_ready_o = (state_q == ST_IDLE) && !rst_i;
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = done_q;
  assign err_count_o = err_count_q;
  assign beats_written_o = beats_written_q;

  // AW fields are driven only while a request is presented, zero otherwise.
  assign axi0_AWVALID_o   = is_aw;
  assign axi0_AWADDR_o    = is_aw ? addr_q : '0;
  assign axi0_AWLEN_o     = is_aw ? len_m1[7:0] : 8'd0;
  assign axi0_AWSIZE_o    = is_aw ? AXI_SIZE_64B : 3'd0;
  assign axi0_AWBURST_o   = is_aw ? AXI_BURST_INCR : 2'd0;
  assign axi0_AWID_o      = is_aw ? AXI_ID : 6'd0;
  assign axi0_AWCACHE_o   = 4'd0;
  assign axi0_AWLOCK_o    = 1'b0;
  assign axi0_AWQOS_o     = 1'b0;
  assign axi0_AWAPCMD_o   = 1'b0;
  assign axi0_AWCOBUF_o   = 1'b0;
  assign axi0_AWALLSTRB_o = is_aw;

  // W is a straight pass-through of the upstream stream while in the data phase.
  assign axi0_WVALID_o = is_w && s_tvalid_i;
  assign s_tready_o    = is_w && axi0_WREADY_i;
  assign axi0_WDATA_o  = is_w ? s_tdata_i : '0;
  assign axi0_WSTRB_o  = is_w ? '1 : '0;
  assign axi0_WLAST_o  = is_w && (beat_cnt_q == 9'd1);

  assign axi0_BREADY_o = is_b;

  assign unused_ok = ^{cmd_addr_i[BEAT_SHIFT-1:0], axi0_BID_i, len_m1[8], BEAT_BYTES[0]};

endmodule

// File: tb/tb_ddr_burst_writer.sv
// tb/tb_ddr_burst_writer.sv - directed table-driven bench for ddr_burst_writer
module tb_ddr_burst_writer;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid, cmd_ready;
  logic [32:0]  cmd_addr;
  logic [15:0]  cmd_beats;
  logic         s_tvalid, s_tready;
  logic [511:0] s_tdata;
  logic         awvalid, awready, awlock, awqos, awapcmd, awcobuf, awallstrb;
  logic [32:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic [5:0]   awid;
  logic [3:0]   awcache;
  logic         wvalid, wready, wlast;
  logic [511:0] wdata;
  logic [63:0]  wstrb;
  logic         bvalid, bready;
  logic [1:0]   bresp;
  logic [5:0]   bid;
  logic         busy, done;
  logic [15:0]  err_count;
  logic [31:0]  beats_written;

  always #5 clk = ~clk;

  ddr_burst_writer dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_addr_i(cmd_addr), .cmd_beats_i(cmd_beats),
    .s_tvalid_i(s_tvalid), .s_tready_o(s_tready), .s_tdata_i(s_tdata),
    .axi0_AWVALID_o(awvalid), .axi0_AWREADY_i(awready), .axi0_AWADDR_o(awaddr), .axi0_AWLEN_o(awlen),
    .axi0_AWSIZE_o(awsize), .axi0_AWBURST_o(awburst), .axi0_AWID_o(awid), .axi0_AWCACHE_o(awcache),
    .axi0_AWLOCK_o(awlock), .axi0_AWQOS_o(awqos), .axi0_AWAPCMD_o(awapcmd), .axi0_AWCOBUF_o(awcobuf),
    .axi0_AWALLSTRB_o(awallstrb),
    .axi0_WVALID_o(wvalid), .axi0_WREADY_i(wready), .axi0_WDATA_o(wdata), .axi0_WSTRB_o(wstrb),
    .axi0_WLAST_o(wlast),
    .axi0_BVALID_i(bvalid), .axi0_BREADY_o(bready), .axi0_BRESP_i(bresp), .axi0_BID_i(bid),
    .busy_o(busy), .done_o(done), .err_count_o(err_count), .beats_written_o(beats_written)
  );

  typedef struct {
    logic [32:0] addr;
    logic [15:0] beats;
    bit          stall;
    logic [1:0]  resp;
    int          exp_nb;
    logic [32:0] exp_a0;
    logic [7:0]  exp_l0;
    logic [32:0] exp_al;
    logic [7:0]  exp_ll;
    int          exp_err;
  } vec_t;

  vec_t        vecs[8];
  int          checks = 0;
  int          errors = 0;
  longint      exp_bw;
  int          exp_err;

  int          r_nb, r_wbeats, r_stable_err, r_data_err, r_last_err, r_proto_err, r_fixed_err;
  int          r_acc_cyc, r_aw_cyc, r_lastb_cyc, r_done_cyc;
  logic [32:0] r_a[8];
  logic [7:0]  r_l[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] mk_data(input int k);
    logic [31:0] w;
    w = 32'(k) ^ 32'hA5C3_0000;
    return {16{w}};
  endfunction

  task automatic drive_idle();
    cmd_valid = 1'b0; cmd_addr = '0; cmd_beats = '0;
    s_tvalid = 1'b0; s_tdata = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = 6'd0;
  endtask

  // Cycle-based slave/source model: drive at negedge, sample 1 ns later.
  task automatic run_desc(input logic [32:0] a, input logic [15:0] n, input bit stall,
                          input logic [1:0] resp, input int abort_at);
    bit          accepted = 1'b0, aw_hold = 1'b0, bpend = 1'b0, stop = 1'b0;
    logic [32:0] h_addr = '0;
    logic [7:0]  h_len = '0;
    int          burst_beat = 0, cur_len = 0;
    r_nb = 0; r_wbeats = 0; r_stable_err = 0; r_data_err = 0; r_last_err = 0;
    r_proto_err = 0; r_fixed_err = 0;
    r_acc_cyc = -1; r_aw_cyc = -1; r_lastb_cyc = -1; r_done_cyc = -1;
    for (int cyc = 0; cyc < 4000 && !stop; cyc++) begin
      @(negedge clk);
      cmd_valid = !accepted; cmd_addr = a; cmd_beats = n;
      awready  = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
      wready   = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      s_tvalid = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      s_tdata  = mk_data(r_wbeats);
      bvalid   = bpend && (stall ? ($urandom_range(0, 1) == 1) : 1'b1);
      bresp    = resp;
      #1;
      if (done) begin
        r_done_cyc = cyc;
        stop = 1'b1;
      end else begin
        if (busy && cmd_ready) r_proto_err++;
        if (cmd_valid && cmd_ready) begin accepted = 1'b1; r_acc_cyc = cyc; end
        if (awvalid) begin
          if (r_aw_cyc < 0) r_aw_cyc = cyc;
          if (aw_hold && (awaddr !== h_addr || awlen !== h_len)) r_stable_err++;
          if (awsize !== 3'b110 || awburst !== 2'b01 || awid !== 6'd0 || awcache !== 4'd0 ||
              awlock !== 1'b0 || awallstrb !== 1'b1) r_fixed_err++;
          if (awready) begin
            if (r_nb < 8) begin r_a[r_nb] = awaddr; r_l[r_nb] = awlen; end
            r_nb++;
            cur_len = int'(awlen) + 1;
            burst_beat = 0;
            aw_hold = 1'b0;
          end else begin
            aw_hold = 1'b1; h_addr = awaddr; h_len = awlen;
          end
        end
        if (bvalid && bready) begin bpend = 1'b0; r_lastb_cyc = cyc; end
        if ((s_tvalid && s_tready) != (wvalid && wready)) r_proto_err++;
        if (wvalid && wready) begin
          if (wdata !== mk_data(r_wbeats) || wstrb !== {64{1'b1}}) r_data_err++;
          burst_beat++;
          if (wlast !== (burst_beat == cur_len)) r_last_err++;
          r_wbeats++;
          if (wlast) bpend = 1'b1;
          if (abort_at > 0 && r_wbeats == abort_at) stop = 1'b1;
        end
      end
    end
    if (abort_at == 0) begin
      @(negedge clk);
      drive_idle();
      #1;
      chk("done_width", {63'd0, done}, 64'd0);
    end
  endtask

  task automatic check_vec(input int i, input vec_t v);
    int li;
    string p;
    p = $sformatf("v%0d_", i);
    li = (r_nb >= 1 && r_nb <= 8) ? r_nb - 1 : 0;
    chk({p, "done_seen"}, {63'd0, r_done_cyc >= 0}, 64'd1);
    chk({p, "bursts"}, 64'(r_nb), 64'(v.exp_nb));
    chk({p, "wbeats"}, 64'(r_wbeats), 64'(v.beats));
    chk({p, "err_count"}, 64'(err_count), 64'(exp_err));
    chk({p, "beats_written"}, 64'(beats_written), 64'(exp_bw));
    chk({p, "aw_stable"}, 64'(r_stable_err), 64'd0);
    chk({p, "wdata"}, 64'(r_data_err), 64'd0);
    chk({p, "wlast"}, 64'(r_last_err), 64'd0);
    chk({p, "handshake"}, 64'(r_proto_err), 64'd0);
    chk({p, "aw_fixed"}, 64'(r_fixed_err), 64'd0);
    if (v.beats == 16'd0) begin
      chk({p, "no_aw"}, 64'(r_aw_cyc), 64'(-1));
      chk({p, "done_lat"}, 64'(r_done_cyc - r_acc_cyc), 64'd1);
    end else begin
      chk({p, "aw_lat"}, 64'(r_aw_cyc - r_acc_cyc), 64'd1);
      chk({p, "done_lat"}, 64'(r_done_cyc - r_lastb_cyc), 64'd1);
      chk({p, "awaddr0"}, 64'(r_a[0]), 64'(v.exp_a0));
      chk({p, "awlen0"}, 64'(r_l[0]), 64'(v.exp_l0));
      chk({p, "awaddr_last"}, 64'(r_a[li]), 64'(v.exp_al));
      chk({p, "awlen_last"}, 64'(r_l[li]), 64'(v.exp_ll));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{33'h0,         16'd3,   1'b0, 2'b00, 1, 33'h0,         8'd2,  33'h0,    8'd2,  0};
`ifdef DDR_WR_4K_SPLIT_EN
    vecs[1] = '{33'h0FC0,      16'd4,   1'b0, 2'b00, 2, 33'h0FC0,      8'd0,  33'h1000, 8'd2,  0};
    vecs[7] = '{33'h1F00,      16'd8,   1'b0, 2'b00, 2, 33'h1F00,      8'd3,  33'h2000, 8'd3,  0};
`else
    vecs[1] = '{33'h0FC0,      16'd4,   1'b0, 2'b00, 1, 33'h0FC0,      8'd3,  33'h0FC0, 8'd3,  0};
    vecs[7] = '{33'h1F00,      16'd8,   1'b0, 2'b00, 1, 33'h1F00,      8'd7,  33'h1F00, 8'd7,  0};
`endif
    vecs[2] = '{33'h0,         16'd200, 1'b0, 2'b00, 4, 33'h0,         8'd63, 33'h3000, 8'd7,  0};
    vecs[3] = '{33'h7F,        16'd10,  1'b1, 2'b00, 1, 33'h40,        8'd9,  33'h40,   8'd9,  0};
    vecs[4] = '{33'h2000,      16'd128, 1'b0, 2'b10, 2, 33'h2000,      8'd63, 33'h3000, 8'd63, 2};
    vecs[5] = '{33'h100,       16'd0,   1'b0, 2'b00, 0, 33'h0,         8'd0,  33'h0,    8'd0,  0};
    vecs[6] = '{33'h1FFFFF000, 16'd65,  1'b0, 2'b00, 2, 33'h1FFFFF000, 8'd63, 33'h0,    8'd0,  0};

    drive_idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    chk("rst_awvalid", {63'd0, awvalid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_bready", {63'd0, bready}, 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    chk("rst_beats_written", 64'(beats_written), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("idle_cmd_ready", {63'd0, cmd_ready}, 64'd1);

    exp_bw = 0;
    exp_err = 0;
    for (int i = 0; i < 8; i++) begin
      run_desc(vecs[i].addr, vecs[i].beats, vecs[i].stall, vecs[i].resp, 0);
      exp_bw  += longint'(vecs[i].beats);
      exp_err += vecs[i].exp_err;
      check_vec(i, vecs[i]);
    end

    // Reset in the middle of the W phase of a 64-beat burst.
    run_desc(33'h0, 16'd64, 1'b0, 2'b00, 10);
    chk("abort_wbeats", 64'(r_wbeats), 64'd10);
    rst = 1'b1;
    #1;
    chk("abort_awvalid", {63'd0, awvalid}, 64'd0);
    chk("abort_wvalid", {63'd0, wvalid}, 64'd0);
    chk("abort_wlast", {63'd0, wlast}, 64'd0);
    chk("abort_s_tready", {63'd0, s_tready}, 64'd0);
    chk("abort_bready", {63'd0, bready}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    chk("abort_wdata", 64'(wdata[63:0]), 64'd0);
    chk("abort_beats_written", 64'(beats_written), 64'd0);
    chk("abort_err_count", 64'(err_count), 64'd0);
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);

    exp_bw = 5;
    exp_err = 0;
    vecs[0] = '{33'h40, 16'd5, 1'b1, 2'b00, 1, 33'h40, 8'd4, 33'h40, 8'd4, 0};
    run_desc(vecs[0].addr, vecs[0].beats, vecs[0].stall, vecs[0].resp, 0);
    check_vec(8, vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
